// File: rtl/sample_delta_encoder_if.sv
// rtl/sample_delta_encoder_if.sv - session control, raw channel input and encoded sample output bundle
interface sample_delta_encoder_if #(
    parameter int CHANNEL   = 16,
    parameter int DATA_BITS = 16
);
    logic                          start_req;
    logic                          stop_req;
    logic [31:0]                   sample_limit;
    logic [DATA_BITS*CHANNEL-1:0]  raw_data;
    logic                          begin_of_sample;
    logic                          sample_running;
    logic [DATA_BITS*CHANNEL-1:0]  data_compressed;
    logic [CHANNEL-1:0]            diff_bitset;
    logic [31:0]                   sample_count;

    modport master (
        output start_req, stop_req, sample_limit, raw_data,
        input  begin_of_sample, sample_running, data_compressed, diff_bitset, sample_count
    );

    modport slave (
        input  start_req, stop_req, sample_limit, raw_data,
        output begin_of_sample, sample_running, data_compressed, diff_bitset, sample_count
    );
endinterface

// File: rtl/sample_delta_encoder.sv
// rtl/sample_delta_encoder.sv - capture session FSM with per-channel change bitset and packed delta values
module sample_delta_encoder #(
    parameter int CHANNEL           = 16,
    parameter int DATA_BITS         = 16,
    parameter int KEYFRAME_INTERVAL = 256,
    parameter int ARM_CYCLES        = 8
) (
    input  logic                    sample_clk,
    input  logic                    tx_clock_rst_n,
    sample_delta_encoder_if.slave   bus
);
    localparam int W     = DATA_BITS * CHANNEL;
    localparam int KF_W  = (KEYFRAME_INTERVAL > 2) ? $clog2(KEYFRAME_INTERVAL) : 1;
    localparam int ARM_W = (ARM_CYCLES > 1) ? $clog2(ARM_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, ARM, RUN} state_t;

    state_t             state_q, state_d;
    logic [W-1:0]       raw_q, prev_q;
    logic [KF_W-1:0]    kf_cnt_q;
    logic               first_q;
    logic [ARM_W-1:0]   arm_cnt_q;
    logic [31:0]        limit_q;
    logic               bos_q, running_q;
    logic [W-1:0]       data_q;
    logic [CHANNEL-1:0] diff_q;
    logic [31:0]        count_q;

    logic               limit_hit;
    logic               arm_entry;
    logic               keyframe;
    logic [CHANNEL-1:0] diff_d;
    logic [W-1:0]       data_d;

    // Session ends on the edge that emits the limit-th sample, so exactly N samples go out.
    assign limit_hit = (limit_q != 32'd0) && (({1'b0, count_q} + 33'd1) == {1'b0, limit_q});
    assign arm_entry = (state_q == IDLE) && (state_d == ARM);
    assign keyframe  = first_q || (kf_cnt_q == KF_W'(KEYFRAME_INTERVAL - 1));

    always_ff @(posedge sample_clk or negedge tx_clock_rst_n) begin
        if (!tx_clock_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (bus.start_req && !bus.stop_req) state_d = ARM;
            ARM: begin
                if (bus.stop_req)                                state_d = IDLE;
                else if (arm_cnt_q == ARM_W'(ARM_CYCLES - 1))    state_d = RUN;
            end
            RUN: if (bus.stop_req || limit_hit) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Changed channels are compacted toward slot 0 in ascending channel order.
    always_comb begin
        int unsigned k;
        diff_d = '0;
        data_d = '0;
        k      = 0;
        for (int c = 0; c < CHANNEL; c++) begin
            diff_d[c] = keyframe || (raw_q[c*DATA_BITS +: DATA_BITS] != prev_q[c*DATA_BITS +: DATA_BITS]);
            if (diff_d[c]) begin
                data_d[k*DATA_BITS +: DATA_BITS] = raw_q[c*DATA_BITS +: DATA_BITS];
                k = k + 1;
            end
        end
    end

    always_ff @(posedge sample_clk or negedge tx_clock_rst_n) begin
        if (!tx_clock_rst_n) begin
            raw_q     <= '0;
            prev_q    <= '0;
            kf_cnt_q  <= '0;
            first_q   <= 1'b0;
            arm_cnt_q <= '0;
            limit_q   <= '0;
            bos_q     <= 1'b0;
            running_q <= 1'b0;
            data_q    <= '0;
            diff_q    <= '0;
            count_q   <= '0;
        end else begin
            raw_q     <= bus.raw_data;
            bos_q     <= (state_d == ARM);
            arm_cnt_q <= (state_q == ARM) ? arm_cnt_q + 1'b1 : '0;
            if (arm_entry) begin
                count_q <= '0;
                limit_q <= bus.sample_limit;
                first_q <= 1'b1;
            end
            if (state_q == RUN) begin
                running_q <= 1'b1;
                diff_q    <= diff_d;
                data_q    <= data_d;
                prev_q    <= raw_q;
                first_q   <= 1'b0;
                kf_cnt_q  <= keyframe ? '0 : kf_cnt_q + 1'b1;
                if (count_q != 32'hFFFF_FFFF) count_q <= count_q + 32'd1;
            end else begin
                running_q <= 1'b0;
                diff_q    <= '0;
                data_q    <= '0;
            end
        end
    end

    assign bus.begin_of_sample = bos_q;
    assign bus.sample_running  = running_q;
    assign bus.data_compressed = data_q;
    assign bus.diff_bitset     = diff_q;
    assign bus.sample_count    = count_q;
endmodule

// File: tb/tb_sample_delta_encoder.sv
// tb/tb_sample_delta_encoder.sv - directed self-checking bench for sample_delta_encoder
module tb_sample_delta_encoder;
    logic sample_clk = 1'b0;
    logic tx_clock_rst_n;
    int   errors = 0;
    int   checks = 0;

    always #5 sample_clk = ~sample_clk;

    sample_delta_encoder_if #(.CHANNEL(4), .DATA_BITS(8)) bus ();

    sample_delta_encoder #(
        .CHANNEL(4), .DATA_BITS(8), .KEYFRAME_INTERVAL(4), .ARM_CYCLES(3)
    ) dut (
        .sample_clk     (sample_clk),
        .tx_clock_rst_n (tx_clock_rst_n),
        .bus            (bus)
    );

    task automatic step();
        @(posedge sample_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [31:0] raw_v  [10] = '{32'h44332211, 32'h44332211, 32'h44992211, 32'h44332211, 32'h44332211,
                                 32'h55332266, 32'h55332266, 32'h55332266, 32'h55332266, 32'h55332266};
    logic [3:0]  diff_v [10] = '{4'hF, 4'h0, 4'h4, 4'h4, 4'hF, 4'h9, 4'h0, 4'h0, 4'hF, 4'h0};
    logic [31:0] data_v [10] = '{32'h44332211, 32'h0, 32'h99, 32'h33, 32'h44332211,
                                 32'h5566, 32'h0, 32'h0, 32'h55332266, 32'h0};

    initial begin
        int bos_cnt;
        int run_cnt;
        tx_clock_rst_n    = 1'b0;
        bus.start_req     = 1'b0;
        bus.stop_req      = 1'b0;
        bus.sample_limit  = 32'd0;
        bus.raw_data      = 32'd0;
        repeat (2) step();
        chk("rst_bos",   bus.begin_of_sample, 1'b0);
        chk("rst_run",   bus.sample_running,  1'b0);
        chk("rst_diff",  bus.diff_bitset,     4'h0);
        chk("rst_data",  bus.data_compressed, 32'h0);
        chk("rst_count", bus.sample_count,    32'd0);

        // Unlimited session: arm timing, first keyframe, deltas, periodic keyframes
        tx_clock_rst_n = 1'b1;
        bus.raw_data   = raw_v[0];
        bus.start_req  = 1'b1;
        step();
        bus.start_req = 1'b0;
        chk("arm_bos1", bus.begin_of_sample, 1'b1);
        step();
        chk("arm_bos2", bus.begin_of_sample, 1'b1);
        step();
        chk("arm_bos3", bus.begin_of_sample, 1'b1);
        step();
        chk("arm_bos_drop", bus.begin_of_sample, 1'b0);
        chk("arm_not_run",  bus.sample_running,  1'b0);
        bus.raw_data = raw_v[1];
        for (int i = 0; i < 10; i++) begin
            step();
            chk($sformatf("s%0d_run", i),   bus.sample_running,  1'b1);
            chk($sformatf("s%0d_diff", i),  bus.diff_bitset,     diff_v[i]);
            chk($sformatf("s%0d_data", i),  bus.data_compressed, data_v[i]);
            chk($sformatf("s%0d_count", i), bus.sample_count,    32'(i + 1));
            if (i < 8) bus.raw_data = raw_v[i + 2];
        end
        bus.stop_req = 1'b1;
        step();
        bus.stop_req = 1'b0;
        chk("stop_last_run",   bus.sample_running, 1'b1);
        chk("stop_last_count", bus.sample_count,   32'd11);
        step();
        chk("stop_run",   bus.sample_running,  1'b0);
        chk("stop_diff",  bus.diff_bitset,     4'h0);
        chk("stop_data",  bus.data_compressed, 32'h0);
        chk("stop_count", bus.sample_count,    32'd11);

        // sample_limit = 5
        bus.sample_limit = 32'd5;
        bus.raw_data     = 32'hA1B2C3D4;
        bus.start_req    = 1'b1;
        step();
        bus.start_req = 1'b0;
        bus.sample_limit = 32'd0;
        bos_cnt = int'(bus.begin_of_sample);
        run_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (bus.begin_of_sample) bos_cnt++;
            if (bus.sample_running) begin
                chk($sformatf("lim_diff%0d", run_cnt), bus.diff_bitset, (run_cnt % 4 == 0) ? 4'hF : 4'h0);
                if (run_cnt % 4 == 0) chk($sformatf("lim_data%0d", run_cnt), bus.data_compressed, 32'hA1B2C3D4);
                run_cnt++;
            end
        end
        chk("lim_bos_cycles", bos_cnt, 3);
        chk("lim_run_cycles", run_cnt, 5);
        chk("lim_count",      bus.sample_count, 32'd5);

        // stop_req during ARM
        bus.start_req = 1'b1;
        step();
        bus.start_req = 1'b0;
        chk("sarm_bos",   bus.begin_of_sample, 1'b1);
        chk("sarm_clear", bus.sample_count,    32'd0);
        bus.stop_req = 1'b1;
        step();
        bus.stop_req = 1'b0;
        chk("sarm_bos_drop", bus.begin_of_sample, 1'b0);
        run_cnt = 0;
        bos_cnt = 0;
        repeat (8) begin
            step();
            if (bus.sample_running)  run_cnt++;
            if (bus.begin_of_sample) bos_cnt++;
        end
        chk("sarm_run_cycles", run_cnt, 0);
        chk("sarm_bos_cycles", bos_cnt, 0);

        // start_req and stop_req together in IDLE
        bus.start_req = 1'b1;
        bus.stop_req  = 1'b1;
        step();
        bus.start_req = 1'b0;
        bus.stop_req  = 1'b0;
        bos_cnt = int'(bus.begin_of_sample);
        run_cnt = 0;
        repeat (6) begin
            step();
            if (bus.sample_running)  run_cnt++;
            if (bus.begin_of_sample) bos_cnt++;
        end
        chk("both_bos_cycles", bos_cnt, 0);
        chk("both_run_cycles", run_cnt, 0);

        // Reset mid-RUN
        bus.start_req = 1'b1;
        step();
        bus.start_req = 1'b0;
        repeat (6) step();
        chk("mid_running", bus.sample_running, 1'b1);
        @(posedge sample_clk);
        #3;
        tx_clock_rst_n = 1'b0;
        #1;
        chk("mid_rst_run",   bus.sample_running,  1'b0);
        chk("mid_rst_bos",   bus.begin_of_sample, 1'b0);
        chk("mid_rst_diff",  bus.diff_bitset,     4'h0);
        chk("mid_rst_data",  bus.data_compressed, 32'h0);
        chk("mid_rst_count", bus.sample_count,    32'd0);
        step();
        step();
        tx_clock_rst_n = 1'b1;
        run_cnt = 0;
        repeat (5) begin
            step();
            if (bus.sample_running) run_cnt++;
        end
        chk("post_rst_run_cycles", run_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
